// File: rtl/cube_ctrl_pkg.sv
// Shared definitions for the LED-cube control slice.
//   db_state_t      : debounce FSM state encoding (2 bits)
//   DEBOUNCE_W_DEF  : default qualify counter width (stable for 2^W cycles)
//   LONG_W_DEF      : default long-press counter width
//   SYNC_STAGES_DEF : default synchronizer depth
package cube_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    QUAL_PRESS = 2'd1,
    PRESSED    = 2'd2,
    QUAL_REL   = 2'd3
  } db_state_t;

  localparam int unsigned DEBOUNCE_W_DEF  = 9;
  localparam int unsigned LONG_W_DEF      = 12;
  localparam int unsigned SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/input_synchronizer.sv
// Multi-flop synchronizer for asynchronous button levels.
// Shared by every board button input.
// Ports:
//   clk    in  system clock
//   reset  in  synchronous, active-high; clears the whole chain to 0
//   d      in  [WIDTH-1:0] asynchronous input
//   q      out [WIDTH-1:0] input after STAGES flops
module input_synchronizer #(
  parameter int unsigned STAGES = 2,
  parameter int unsigned WIDTH  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain_q [STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < STAGES; i++) chain_q[i] <= '0;
    end else begin
      chain_q[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) chain_q[i] <= chain_q[i-1];
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/debounce_pulser.sv
// Button debouncer: turns a raw bouncing level into a clean debounced level
// plus a one-cycle strobe per qualified press. The input must be stable for
// 2^DEBOUNCE_W cycles (after synchronization) to change level_out.
// Optional feature macro: LONG_PRESS_EN adds a one-cycle strobe after a press
// has been held for a further 2^LONG_W cycles.
// Ports:
//   clk             in   system clock
//   reset           in   synchronous, active-high reset
//   level_in        in   raw asynchronous button level, active-high
//   level_out       out  debounced level (registered)
//   pulse_out       out  one-cycle strobe per qualified press (registered)
//   long_pulse_out  out  one-cycle strobe after a long hold (0 without LONG_PRESS_EN)
module debounce_pulser
  import cube_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_W  = DEBOUNCE_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned LONG_W      = LONG_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic level_in,
  output logic level_out,
  output logic pulse_out,
  output logic long_pulse_out
);

  localparam logic [DEBOUNCE_W-1:0] CNT_MAX = '1;

  logic                  sync_in;
  db_state_t             state_q, state_d;
  logic [DEBOUNCE_W-1:0] cnt_q, cnt_d;
  logic                  level_q, level_d;
  logic                  pulse_q, pulse_d;

  input_synchronizer #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (level_in),
    .q     (sync_in)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        level_d = 1'b0;
        if (sync_in) begin
          state_d = QUAL_PRESS;
          cnt_d   = '0;
        end
      end
      QUAL_PRESS: begin
        if (!sync_in) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = PRESSED;
          level_d = 1'b1;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        level_d = 1'b1;
        if (!sync_in) begin
          state_d = QUAL_REL;
          cnt_d   = '0;
        end
      end
      QUAL_REL: begin
        // A bounce back to 1 returns to PRESSED silently; only the
        // QUAL_PRESS -> PRESSED transition ever raises pulse_out.
        if (sync_in) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  assign level_out = level_q;
  assign pulse_out = pulse_q;

`ifdef LONG_PRESS_EN
  localparam logic [LONG_W-1:0] LCNT_MAX = '1;

  logic [LONG_W-1:0] lcnt_q, lcnt_d;
  logic              long_done_q, long_done_d;
  logic              long_q, long_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      lcnt_q      <= '0;
      long_done_q <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      lcnt_q      <= lcnt_d;
      long_done_q <= long_done_d;
      long_q      <= long_d;
    end
  end

  // Counting is keyed on the registered state, so the hold count starts on
  // the first cycle spent in PRESSED; the strobe lands 2^LONG_W cycles after
  // pulse_out.
  always_comb begin
    lcnt_d      = lcnt_q;
    long_done_d = long_done_q;
    long_d      = 1'b0;
    if (state_q == QUAL_PRESS && state_d == PRESSED) begin
      lcnt_d      = '0;
      long_done_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          lcnt_d      = '0;
          long_done_d = 1'b0;
        end
        PRESSED: begin
          if (!long_done_q) begin
            if (lcnt_q == LCNT_MAX) begin
              long_d      = 1'b1;
              long_done_d = 1'b1;
            end else begin
              lcnt_d = lcnt_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign long_pulse_out = long_q;
`else
  logic long_w_unused;
  assign long_w_unused  = (LONG_W == 0);
  assign long_pulse_out = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_pulser.sv
module tb_debounce_pulser;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic level_in = 1'b0;
  logic level_out, pulse_out, long_pulse_out;

  always #5 clk = ~clk;

  debounce_pulser #(
    .DEBOUNCE_W  (9),
    .SYNC_STAGES (2),
    .LONG_W      (12)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .level_in       (level_in),
    .level_out      (level_out),
    .pulse_out      (pulse_out),
    .long_pulse_out (long_pulse_out)
  );

  typedef struct {
    logic lvl;
    logic pulse;
    logic lng;
    int   edge_no;
  } exp_t;

  typedef struct {
    string name;
    logic  first;
    int    nseg;
    int    seg [16];
    int    pulse_edge;
    int    fall_edge;
    int    long_edge;
  } scen_t;

  exp_t  sb_q [$];
  exp_t  mon_e;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  string cur_name = "init";
  scen_t tbl [5];

  task automatic check(input string what, input logic act, input logic exp, input int e);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s edge %0d: got %b expected %b", cur_name, what, e, act, exp);
    end
  endtask

  // Outputs are sampled on the falling edge following the edge that produced them.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check("level_out", level_out, mon_e.lvl, mon_e.edge_no);
      check("pulse_out", pulse_out, mon_e.pulse, mon_e.edge_no);
      check("long_pulse_out", long_pulse_out, mon_e.lng, mon_e.edge_no);
    end
  end

  task automatic step(input logic lvl, input logic rst, input logic el,
                      input logic ep, input logic elg, input int e);
    level_in = lvl;
    reset    = rst;
    @(posedge clk);
    sb_q.push_back('{lvl: el, pulse: ep, lng: elg, edge_no: e});
    #1;
  endtask

  task automatic do_reset();
    cur_name = "reset";
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, i);
  endtask

  task automatic run_scen(input scen_t s);
    logic lvl;
    int   e;
    logic el, ep, elg;
    cur_name = s.name;
    lvl = s.first;
    e = 0;
    for (int si = 0; si < s.nseg; si++) begin
      for (int k = 0; k < s.seg[si]; k++) begin
        el  = (s.pulse_edge >= 0) && (e >= s.pulse_edge) && (e < s.fall_edge);
        ep  = (e == s.pulse_edge);
        elg = (e == s.long_edge);
        step(lvl, 1'b0, el, ep, elg, e);
        e++;
      end
      lvl = ~lvl;
    end
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
  endtask

  initial begin
    #2000000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    summary();
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Edge numbers are relative to each scenario; level_in changes take
    // effect at the listed edge, outputs follow 2 + 512 edges later.
    tbl[0].name = "clean_press"; tbl[0].first = 1'b0; tbl[0].nseg = 3;
    tbl[0].seg = '{default: 0};
    tbl[0].seg[0] = 10; tbl[0].seg[1] = 2000; tbl[0].seg[2] = 700;
    tbl[0].pulse_edge = 524; tbl[0].fall_edge = 2524; tbl[0].long_edge = -1;

    tbl[1].name = "press_bounce"; tbl[1].first = 1'b0; tbl[1].nseg = 13;
    tbl[1].seg = '{default: 0};
    tbl[1].seg[0] = 10;
    for (int i = 1; i <= 10; i++) tbl[1].seg[i] = 100;
    tbl[1].seg[11] = 1000; tbl[1].seg[12] = 700;
    tbl[1].pulse_edge = 1524; tbl[1].fall_edge = 2524; tbl[1].long_edge = -1;

    tbl[2].name = "glitch"; tbl[2].first = 1'b0; tbl[2].nseg = 3;
    tbl[2].seg = '{default: 0};
    tbl[2].seg[0] = 10; tbl[2].seg[1] = 300; tbl[2].seg[2] = 700;
    tbl[2].pulse_edge = -1; tbl[2].fall_edge = -1; tbl[2].long_edge = -1;

    tbl[3].name = "release_bounce"; tbl[3].first = 1'b0; tbl[3].nseg = 5;
    tbl[3].seg = '{default: 0};
    tbl[3].seg[0] = 10; tbl[3].seg[1] = 1000; tbl[3].seg[2] = 200;
    tbl[3].seg[3] = 50; tbl[3].seg[4] = 700;
    tbl[3].pulse_edge = 524; tbl[3].fall_edge = 1774; tbl[3].long_edge = -1;

    tbl[4].name = "long_hold"; tbl[4].first = 1'b0; tbl[4].nseg = 3;
    tbl[4].seg = '{default: 0};
    tbl[4].seg[0] = 10; tbl[4].seg[1] = 6000; tbl[4].seg[2] = 700;
    tbl[4].pulse_edge = 524; tbl[4].fall_edge = 6524;
`ifdef LONG_PRESS_EN
    tbl[4].long_edge = 4620;
`else
    tbl[4].long_edge = -1;
`endif

    do_reset();
    for (int t = 0; t < 5; t++) begin
      run_scen(tbl[t]);
      do_reset();
    end

    // Reset while qualifying (edge 300) and again while pressed (edge 1000),
    // level_in held high; each time qualification restarts from scratch.
    cur_name = "reset_mid";
    for (int e = 0; e < 2400; e++) begin
      step((e < 1700), (e == 300 || e == 1000),
           ((e >= 815 && e < 1000) || (e >= 1515 && e < 2214)),
           (e == 815 || e == 1515), 1'b0, e);
    end

    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2400);
    @(negedge clk);
    #1;
    cur_name = "drain";
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain.queue: got %0d entries expected 0", sb_q.size());
    end

    summary();
    $finish;
  end

endmodule
